// File: rtl/clock_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// clock_ctrl_pkg
// Shared types and defaults for the time-of-day set controller.
//   mode_t       : controller mode; the encoding is driven out unchanged as
//                  field_sel (0 RUN, 1 SET_HR, 2 SET_MIN, 3 SET_SEC).
//   *_DEF        : default periods in clock cycles for a 50 MHz clock.
//   next_mode()  : mode sequence applied on each mode-button press.
// -----------------------------------------------------------------------------
package clock_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2,
    SET_SEC = 2'd3
  } mode_t;

  localparam int REPEAT_DLY_DEF = 25_000_000;  // 0.5 s hold before auto-repeat
  localparam int REPEAT_PER_DEF = 5_000_000;   // 10 repeats per second
  localparam int BLINK_PER_DEF  = 12_500_000;  // 0.25 s blink half-period
  localparam int TIMEOUT_DEF    = 500_000_000; // 10 s idle before back to RUN

  // RUN -> SET_HR -> SET_MIN -> SET_SEC -> RUN
  function automatic mode_t next_mode(input mode_t m);
    mode_t n;
    case (m)
      RUN:     n = SET_HR;
      SET_HR:  n = SET_MIN;
      SET_MIN: n = SET_SEC;
      default: n = RUN;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/clock_set_ctrl_if.sv
// -----------------------------------------------------------------------------
// clock_set_ctrl_if
// Groups the button inputs and counter-chain control outputs of
// clock_set_ctrl.
//   mode_btn, adj_btn : debounced, synchronous, active-high levels (master drives)
//   run_en            : chain enable, high only in RUN
//   inc_hr, inc_min   : one-cycle increment pulses
//   clr_sec           : one-cycle seconds/tick clear pulse
//   field_sel         : current mode (mode_t encoding)
//   blink             : display blank toggle for the selected field
//   state_dbg         : FSM state, for checkers
// Signalling: there is no valid/ready pair on this block. Buttons are plain
// levels sampled on every rising clock edge and only their rising edges (plus
// the hold duration of adj_btn) carry meaning. Every output is a register
// updated on the edge that decided it; pulses are high for exactly one cycle
// and are never accepted or back-pressured by the receiver.
// -----------------------------------------------------------------------------
interface clock_set_ctrl_if;
  import clock_ctrl_pkg::*;

  logic       mode_btn;
  logic       adj_btn;
  logic       run_en;
  logic       inc_hr;
  logic       inc_min;
  logic       clr_sec;
  logic [1:0] field_sel;
  logic       blink;
  mode_t      state_dbg;

  modport master (
    output mode_btn, adj_btn,
    input  run_en, inc_hr, inc_min, clr_sec, field_sel, blink, state_dbg
  );

  modport slave (
    input  mode_btn, adj_btn,
    output run_en, inc_hr, inc_min, clr_sec, field_sel, blink, state_dbg
  );

endinterface

// File: rtl/clock_set_ctrl_btn_repeat.sv
// -----------------------------------------------------------------------------
// btn_repeat
// Rise detection, hold timing and auto-repeat for a single push-button.
//   clock, reset_n : clock and asynchronous active-low reset
//   btn            : debounced button level
//   active         : the current edge may act on the button; when low the hold
//                    is cancelled and the button must be released and pressed
//                    again before anything else is produced
//   rpt_en         : auto-repeat permitted for the current hold
//   press          : combinational pulse on an accepted rising edge
//   rpt            : combinational pulse for each auto-repeat
// The rise edge loads the hold counter with 1, so the counter holds the number
// of held edges so far. The first repeat fires when it reaches DLY, after which
// it restarts at 1 and fires every PER edges.
// -----------------------------------------------------------------------------
module btn_repeat #(
  parameter int DLY = 8,
  parameter int PER = 4
) (
  input  logic clock,
  input  logic reset_n,
  input  logic btn,
  input  logic active,
  input  logic rpt_en,
  output logic press,
  output logic rpt
);

  localparam int CNT_TOP = (DLY > PER) ? DLY : PER;
  localparam int CW      = $clog2(CNT_TOP + 1);

  localparam logic [CW-1:0] DLY_C = CW'(DLY);
  localparam logic [CW-1:0] PER_C = CW'(PER);
  localparam logic [CW-1:0] TOP_C = CW'(CNT_TOP);
  localparam logic [CW-1:0] ONE_C = CW'(1);

  logic          btn_q,   btn_d;
  logic          armed_q, armed_d;  // current hold was accepted as a press
  logic          phase_q, phase_d;  // 0: initial delay, 1: repeating
  logic [CW-1:0] cnt_q,   cnt_d;
  logic          rise;

  always_comb begin
    btn_d   = btn;
    armed_d = armed_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    press   = 1'b0;
    rpt     = 1'b0;
    rise    = btn & ~btn_q;

    if (!btn || !active) begin
      // Release or cancellation both drop the hold immediately.
      armed_d = 1'b0;
      phase_d = 1'b0;
      cnt_d   = '0;
    end else if (rise) begin
      press   = 1'b1;
      armed_d = 1'b1;
      phase_d = 1'b0;
      cnt_d   = ONE_C;
    end else if (armed_q && rpt_en) begin
      if (!phase_q && (cnt_q == DLY_C)) begin
        rpt     = 1'b1;
        phase_d = 1'b1;
        cnt_d   = ONE_C;
      end else if (phase_q && (cnt_q == PER_C)) begin
        rpt   = 1'b1;
        cnt_d = ONE_C;
      end else if (cnt_q != TOP_C) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      btn_q   <= 1'b0;
      armed_q <= 1'b0;
      phase_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      btn_q   <= btn_d;
      armed_q <= armed_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/clock_set_ctrl.sv
// -----------------------------------------------------------------------------
// clock_set_ctrl
// Mode/adjust controller for the HH:MM:SS counter chain. The mode button steps
// RUN -> SET_HR -> SET_MIN -> SET_SEC -> RUN; the adjust button increments the
// selected field (with auto-repeat for hours and minutes) or clears seconds.
//   clock, reset_n : 50 MHz clock, asynchronous active-low reset
//   bus (slave)    : buttons in; run_en, inc_hr, inc_min, clr_sec, field_sel,
//                    blink and state_dbg out (all registered, 1-cycle latency)
// Optional build macro CLOCK_SET_CTRL_TIMEOUT_EN adds an idle counter that
// returns the controller to RUN after TIMEOUT cycles without a button rise in
// a SET mode. Without it SET modes persist until the mode button is pressed.
// -----------------------------------------------------------------------------
module clock_set_ctrl
  import clock_ctrl_pkg::*;
#(
  parameter int REPEAT_DLY = REPEAT_DLY_DEF,
  parameter int REPEAT_PER = REPEAT_PER_DEF,
  parameter int BLINK_PER  = BLINK_PER_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input logic             clock,
  input logic             reset_n,
  clock_set_ctrl_if.slave bus
);

  if (REPEAT_DLY < 1 || REPEAT_PER < 1 || BLINK_PER < 1 || TIMEOUT < 1) begin : g_param_err
    $error("clock_set_ctrl: all periods must be at least 1 cycle");
  end

  localparam int BW = $clog2(BLINK_PER + 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_PER - 1);

  mode_t         state_q,   state_d;
  logic          mode_q;
  logic          run_en_q,  run_en_d;
  logic          inc_hr_q,  inc_hr_d;
  logic          inc_min_q, inc_min_d;
  logic          clr_sec_q, clr_sec_d;
  logic          blink_q,   blink_d;
  logic [BW-1:0] bcnt_q,    bcnt_d;

  logic mode_rise;
  logic timeout_hit;
  logic adj_active;
  logic adj_rpt_en;
  logic adj_press;
  logic adj_rpt;

  assign mode_rise = bus.mode_btn & ~mode_q;

  // A mode change (button or timeout) on this edge wins over adj and cancels
  // any hold in progress; RUN ignores adj altogether.
  assign adj_active = (state_q != RUN) && !mode_rise && !timeout_hit;
  assign adj_rpt_en = (state_q == SET_HR) || (state_q == SET_MIN);

  btn_repeat #(
    .DLY (REPEAT_DLY),
    .PER (REPEAT_PER)
  ) u_adj (
    .clock   (clock),
    .reset_n (reset_n),
    .btn     (bus.adj_btn),
    .active  (adj_active),
    .rpt_en  (adj_rpt_en),
    .press   (adj_press),
    .rpt     (adj_rpt)
  );

`ifdef CLOCK_SET_CTRL_TIMEOUT_EN
  localparam int IW = $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT - 1);

  logic [IW-1:0] idle_q, idle_d;
  logic          adj_q;
  logic          adj_rise;

  assign adj_rise = bus.adj_btn & ~adj_q;

  always_comb begin
    idle_d      = idle_q;
    timeout_hit = 1'b0;
    if ((state_q == RUN) || mode_rise || adj_rise) begin
      idle_d = '0;
    end else if (idle_q == IDLE_LAST) begin
      // This edge completes TIMEOUT idle cycles.
      timeout_hit = 1'b1;
      idle_d      = '0;
    end else begin
      idle_d = idle_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      idle_q <= '0;
      adj_q  <= 1'b0;
    end else begin
      idle_q <= idle_d;
      adj_q  <= bus.adj_btn;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    run_en_d  = 1'b1;
    inc_hr_d  = 1'b0;
    inc_min_d = 1'b0;
    clr_sec_d = 1'b0;
    blink_d   = blink_q;
    bcnt_d    = bcnt_q;

    if (mode_rise) begin
      state_d = next_mode(state_q);
    end else if (timeout_hit) begin
      state_d = RUN;
    end

    run_en_d = (state_d == RUN);

    // press/rpt only occur when state is unchanged, so state_q selects the
    // field and at most one pulse output is set.
    inc_hr_d  = (adj_press | adj_rpt) && (state_q == SET_HR);
    inc_min_d = (adj_press | adj_rpt) && (state_q == SET_MIN);
    clr_sec_d = adj_press && (state_q == SET_SEC);

    if (state_d == RUN) begin
      blink_d = 1'b0;
      bcnt_d  = '0;
    end else if (mode_rise) begin
      // Entering a SET mode starts with the field blanked-on phase.
      blink_d = 1'b1;
      bcnt_d  = '0;
    end else if (bcnt_q == BLINK_LAST) begin
      blink_d = ~blink_q;
      bcnt_d  = '0;
    end else begin
      bcnt_d = bcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= RUN;
      mode_q    <= 1'b0;
      run_en_q  <= 1'b1;
      inc_hr_q  <= 1'b0;
      inc_min_q <= 1'b0;
      clr_sec_q <= 1'b0;
      blink_q   <= 1'b0;
      bcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= bus.mode_btn;
      run_en_q  <= run_en_d;
      inc_hr_q  <= inc_hr_d;
      inc_min_q <= inc_min_d;
      clr_sec_q <= clr_sec_d;
      blink_q   <= blink_d;
      bcnt_q    <= bcnt_d;
    end
  end

  assign bus.run_en    = run_en_q;
  assign bus.inc_hr    = inc_hr_q;
  assign bus.inc_min   = inc_min_q;
  assign bus.clr_sec   = clr_sec_q;
  assign bus.field_sel = state_q;
  assign bus.blink     = blink_q;
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clock_set_ctrl
// Self-checking bench for clock_set_ctrl with short periods. A behavioural
// model tracks the mode index, the age of the current adj hold and the age of
// the current SET mode, and derives expected outputs from them arithmetically.
// Directed sequences are followed by a randomized button phase.
// -----------------------------------------------------------------------------
module tb_clock_set_ctrl;
  import clock_ctrl_pkg::*;

  localparam int P_DLY     = 8;
  localparam int P_PER     = 4;
  localparam int P_BLINK   = 3;
  localparam int P_TIMEOUT = 20;

  logic clock;
  logic reset_n;

  clock_set_ctrl_if bus ();

  clock_set_ctrl #(
    .REPEAT_DLY (P_DLY),
    .REPEAT_PER (P_PER),
    .BLINK_PER  (P_BLINK),
    .TIMEOUT    (P_TIMEOUT)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_mode;          // 0 RUN, 1 HR, 2 MIN, 3 SEC
  bit m_pmb, m_pab;    // button levels at the previous edge
  bit m_armed;         // a valid hold is in progress
  int m_hold;          // edges since the accepted adj rise
  int m_set_age;       // edges since entry into the current SET mode
  int m_idle;          // edges since the last button rise in a SET mode
  bit e_hr, e_min, e_sec;

  // pulse counters over a window, for the directed checks
  int w_hr, w_min, w_sec;

  task automatic model_reset();
    m_mode = 0; m_pmb = 0; m_pab = 0; m_armed = 0;
    m_hold = 0; m_set_age = 0; m_idle = 0;
    e_hr = 0; e_min = 0; e_sec = 0;
  endtask

  task automatic model_edge(input bit mb, input bit ab);
    bit mr, ar, tout, pulse;
    mr = mb && !m_pmb;
    ar = ab && !m_pab;
    m_pmb = mb;
    m_pab = ab;
    pulse = 0;
    tout  = 0;
`ifdef CLOCK_SET_CTRL_TIMEOUT_EN
    tout = (m_mode != 0) && !mr && !ar && (m_idle + 1 == P_TIMEOUT);
`endif
    if (mr) begin
      m_mode = (m_mode + 1) % 4;
      m_armed = 0; m_set_age = 0; m_idle = 0;
    end else if (tout) begin
      m_mode = 0;
      m_armed = 0;
    end else if (m_mode != 0) begin
      m_set_age++;
      if (ar) begin
        m_armed = 1; m_hold = 0; pulse = 1; m_idle = 0;
      end else begin
        m_idle++;
        if (ab && m_armed) begin
          m_hold++;
          if (m_mode != 3 && m_hold >= P_DLY && ((m_hold - P_DLY) % P_PER) == 0)
            pulse = 1;
        end
      end
      if (!ab) m_armed = 0;
    end else begin
      m_armed = 0;
    end
    e_hr  = pulse && (m_mode == 1);
    e_min = pulse && (m_mode == 2);
    e_sec = pulse && (m_mode == 3);
  endtask

  task automatic check_outputs();
    int npulse;
    bit e_blink;
    e_blink = (m_mode != 0) && (((m_set_age / P_BLINK) % 2) == 0);
    check_eq("run_en",    bus.run_en,    (m_mode == 0));
    check_eq("field_sel", bus.field_sel, m_mode);
    check_eq("state_dbg", 32'(bus.state_dbg), m_mode);
    check_eq("inc_hr",    bus.inc_hr,    e_hr);
    check_eq("inc_min",   bus.inc_min,   e_min);
    check_eq("clr_sec",   bus.clr_sec,   e_sec);
    check_eq("blink",     bus.blink,     e_blink);
    npulse = int'(bus.inc_hr) + int'(bus.inc_min) + int'(bus.clr_sec);
    check_eq("pulse_onehot", (npulse > 1), 0);
    w_hr  += int'(bus.inc_hr);
    w_min += int'(bus.inc_min);
    w_sec += int'(bus.clr_sec);
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_run_en"},  bus.run_en,    1);
    check_eq({tag, "_fsel"},    bus.field_sel, 0);
    check_eq({tag, "_inc_hr"},  bus.inc_hr,    0);
    check_eq({tag, "_inc_min"}, bus.inc_min,   0);
    check_eq({tag, "_clr_sec"}, bus.clr_sec,   0);
    check_eq({tag, "_blink"},   bus.blink,     0);
  endtask

  // ---------------- driver ----------------
  // Called just after a falling edge: drive inputs, advance the model across
  // the coming rising edge, then check at the next falling edge.
  task automatic step(input logic mb, input logic ab);
    bus.mode_btn = mb;
    bus.adj_btn  = ab;
    model_edge(mb, ab);
    @(posedge clock);
    @(negedge clock);
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  task automatic press_mode();
    step(1'b1, 1'b0);
    idle(4);
  endtask

  task automatic clear_window();
    w_hr = 0; w_min = 0; w_sec = 0;
  endtask

  task automatic goto_mode(input int target);
    for (int i = 0; i < 8 && m_mode != target; i++) press_mode();
    check_eq("goto_mode", m_mode, target);
  endtask

  // ---------------- sequence ----------------
  initial begin
    logic rm, ra;
    reset_n      = 1'b0;
    bus.mode_btn = 1'b0;
    bus.adj_btn  = 1'b0;
    model_reset();
    clear_window();
    repeat (3) @(negedge clock);
    check_reset_values("in_reset");
    reset_n = 1'b1;

    // Idle after reset
    idle(50);

    // Four mode presses, 5 cycles apart
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0);
      check_eq("fsel_seq", bus.field_sel, (i + 1) % 4);
      check_eq("run_en_seq", bus.run_en, (i == 3));
      idle(4);
    end

    // SET_MIN: adj held 20 cycles -> inc_min at 1, 9, 13, 17
    goto_mode(2);
    clear_window();
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1);
    check_eq("min_rpt_count", w_min, 4);
    check_eq("min_rpt_hr", w_hr, 0);
    check_eq("min_rpt_sec", w_sec, 0);
    idle(3);

    // SET_SEC: adj held 20 cycles -> one clr_sec
    press_mode();
    clear_window();
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1);
    check_eq("sec_hold_count", w_sec, 1);
    idle(3);

    // RUN: adj pulses and a long hold are ignored
    press_mode();
    clear_window();
    for (int i = 0; i < 5; i++) begin step(1'b0, 1'b1); step(1'b0, 1'b0); end
    for (int i = 0; i < 15; i++) step(1'b0, 1'b1);
    idle(2);
    check_eq("run_adj_pulses", w_hr + w_min + w_sec, 0);

    // SET_HR: mode and adj rise together -> SET_MIN, no pulses until re-press
    press_mode();
    clear_window();
    step(1'b1, 1'b1);
    check_eq("simul_fsel", bus.field_sel, 2);
    for (int i = 0; i < 14; i++) step(1'b0, 1'b1);
    check_eq("simul_no_pulse", w_hr + w_min, 0);
    step(1'b0, 1'b0);
    clear_window();
    step(1'b0, 1'b1);
    check_eq("repress_inc_min", bus.inc_min, 1);
    idle(2);
    goto_mode(0);

    // Idle in SET_HR beyond TIMEOUT
    press_mode();
    idle(P_TIMEOUT + 5);
`ifdef CLOCK_SET_CTRL_TIMEOUT_EN
    check_eq("timeout_fsel", bus.field_sel, 0);
    check_eq("timeout_run_en", bus.run_en, 1);
`else
    check_eq("no_timeout_fsel", bus.field_sel, 1);
    check_eq("no_timeout_run_en", bus.run_en, 0);
`endif

    // Reset mid-hold in SET_HR
    goto_mode(1);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1);
    #2 reset_n = 1'b0;
    #1 check_reset_values("mid_reset");
    @(posedge clock);
    @(negedge clock);
    check_reset_values("mid_reset_hold");
    bus.mode_btn = 1'b0;
    bus.adj_btn  = 1'b0;
    model_reset();
    reset_n = 1'b1;
    idle(5);

    // Randomized button activity
    ra = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      rm = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 11) == 0) ra = ~ra;
      step(rm, ra);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
